// File: rtl/csa_accumulator_if.sv
// Handshake bundle for csa_accumulator: beat input stream and result output stream.
// master = producer/consumer side (testbench or upstream logic), slave = accumulator.
interface csa_accumulator_if #(
  parameter int N = 9,
  parameter int W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_x;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_y;
  logic [15:0]    out_beats;
  logic           out_ovf;

  modport master (
    output in_valid, in_x, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_x, in_last, out_ready,
    output in_ready, out_valid, out_y, out_beats, out_ovf
  );
endinterface

// File: rtl/csa_accumulator.sv
// Multi-beat carry-save accumulator with a single registered carry-propagate stage.
// Optional macro CSA_ACC_OVF_EN widens the internal datapath by GUARD bits and drives out_ovf.
module csa_accumulator #(
  parameter int N     = 9,
  parameter int W     = 32,
  parameter int GUARD = 8
) (
  input logic             clk,
  input logic             rst_n,
  csa_accumulator_if.slave bus
);

`ifdef CSA_ACC_OVF_EN
  localparam int WI = W + GUARD;
`else
  localparam int WI = W;
`endif
  localparam int NOPS = N + 2;

  if (N < 2 || N > 16 || W < 8 || W > 64 || GUARD < 1 || GUARD > 16) begin : g_param_check
    $error("csa_accumulator: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  state_t           state_r;
  logic [WI-1:0]    sum_r;
  logic [WI-1:0]    carry_r;
  logic [15:0]      beats_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [W-1:0]     out_y_r;
  logic [15:0]      out_beats_r;
  logic [NOPS*WI-1:0] ops_s;
  logic [WI-1:0]    next_sum_s;
  logic [WI-1:0]    next_carry_s;
  logic [WI-1:0]    total_s;

  // Wallace-style reduction: each level compresses every full triple 3:2, passing leftovers through,
  // until two rows remain. Carries wrap at WI bits, which keeps the pair congruent mod 2^WI.
  function automatic logic [2*WI-1:0] csa_reduce(input logic [NOPS*WI-1:0] ops);
    logic [WI-1:0] v [NOPS];
    logic [WI-1:0] t [NOPS];
    int cnt;
    int nxt;
    for (int i = 0; i < NOPS; i++) v[i] = ops[i*WI +: WI];
    cnt = NOPS;
    for (int lvl = 0; lvl < NOPS; lvl++) begin
      if (cnt > 2) begin
        for (int i = 0; i < NOPS; i++) t[i] = '0;
        nxt = 0;
        for (int i = 0; i < NOPS; i += 3) begin
          if (i + 2 < cnt) begin
            t[nxt]     = v[i] ^ v[i+1] ^ v[i+2];
            t[nxt + 1] = ((v[i] & v[i+1]) | (v[i] & v[i+2]) | (v[i+1] & v[i+2])) << 1;
            nxt        = nxt + 2;
          end else if (i + 1 < cnt) begin
            t[nxt]     = v[i];
            t[nxt + 1] = v[i+1];
            nxt        = nxt + 2;
          end else if (i < cnt) begin
            t[nxt]     = v[i];
            nxt        = nxt + 1;
          end else begin
            nxt        = nxt;
          end
        end
        v   = t;
        cnt = nxt;
      end else begin
        cnt = cnt;
      end
    end
    return {v[1], v[0]};
  endfunction

  // Gather the running pair and zero-extended operands, reduce to the next carry-save pair.
  always_comb begin
    ops_s = '0;
    ops_s[0 +: WI]  = sum_r;
    ops_s[WI +: WI] = carry_r;
    for (int i = 0; i < N; i++) begin
      ops_s[(i+2)*WI +: WI] = WI'(bus.in_x[i*W +: W]);
    end
    {next_carry_s, next_sum_s} = csa_reduce(ops_s);
    total_s = sum_r + carry_r;
  end

`ifdef CSA_ACC_OVF_EN
  logic out_ovf_r;
`endif

  // Packet FSM: accumulate in ACC, resolve the carry-save pair once, hold the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACC;
      sum_r       <= '0;
      carry_r     <= '0;
      beats_r     <= 16'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_y_r     <= '0;
      out_beats_r <= 16'd0;
`ifdef CSA_ACC_OVF_EN
      out_ovf_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ACC: begin
          out_valid_r <= 1'b0;
          if (bus.in_valid && in_ready_r) begin
            sum_r   <= next_sum_s;
            carry_r <= next_carry_s;
            beats_r <= (beats_r == 16'hFFFF) ? beats_r : beats_r + 16'd1;
            if (bus.in_last) begin
              state_r    <= RESOLVE;
              in_ready_r <= 1'b0;
            end else begin
              in_ready_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RESOLVE: begin
          out_y_r     <= total_s[W-1:0];
          out_beats_r <= beats_r;
`ifdef CSA_ACC_OVF_EN
          out_ovf_r   <= |total_s[WI-1:W];
`endif
          out_valid_r <= 1'b1;
          in_ready_r  <= 1'b0;
          state_r     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            sum_r       <= '0;
            carry_r     <= '0;
            beats_r     <= 16'd0;
            state_r     <= ACC;
          end else begin
            out_valid_r <= 1'b1;
            in_ready_r  <= 1'b0;
          end
        end
        default: begin
          state_r     <= ACC;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_y     = out_y_r;
  assign bus.out_beats = out_beats_r;
`ifdef CSA_ACC_OVF_EN
  assign bus.out_ovf   = out_ovf_r;
`else
  assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed + randomized bench for csa_accumulator; reference model sums packets with plain arithmetic.
// Honours CSA_ACC_OVF_EN for the expected out_ovf value.
module tb_csa_accumulator;
  localparam int N     = 9;
  localparam int W     = 32;
  localparam int GUARD = 8;
`ifdef CSA_ACC_OVF_EN
  localparam int WI = W + GUARD;
`else
  localparam int WI = W;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [127:0] m_total;
  int           m_beats;
  logic [W-1:0] q_y[$];
  logic [15:0]  q_b[$];
  logic         q_o[$];

  csa_accumulator_if #(.N(N), .W(W)) bus ();

  csa_accumulator #(.N(N), .W(W), .GUARD(GUARD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] rand_x();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'({$urandom, $urandom});
    return r;
  endfunction

  function automatic logic [N*W-1:0] fill_x(input logic [W-1:0] val);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = val;
    return r;
  endfunction

  // Reference: packet total is the plain integer sum of every accepted operand.
  task automatic model_beat(input logic [N*W-1:0] x, input bit last);
    logic [127:0] wrapped;
    for (int i = 0; i < N; i++) m_total = m_total + 128'(x[i*W +: W]);
    m_beats++;
    if (last) begin
      wrapped = m_total & ((128'd1 << WI) - 128'd1);
      q_y.push_back(m_total[W-1:0]);
      q_b.push_back((m_beats > 65535) ? 16'hFFFF : 16'(m_beats));
`ifdef CSA_ACC_OVF_EN
      q_o.push_back((wrapped >> W) != 128'd0);
`else
      q_o.push_back(1'b0);
`endif
      m_total = 128'd0;
      m_beats = 0;
    end
  endtask

  // One clock: drive at the falling edge, judge handshakes from registered outputs, advance.
  task automatic cycle(input bit v, input bit last, input logic [N*W-1:0] x, input bit rdy,
                       output bit acc);
    bus.in_valid  = v;
    bus.in_last   = last;
    bus.in_x      = x;
    bus.out_ready = rdy;
    acc = v && bus.in_ready;
    if (bus.out_valid) begin
      if (q_y.size() == 0) begin
        chk("spurious_out_valid", bus.out_valid, 1'b0);
      end else begin
        chk("out_y", bus.out_y, q_y[0]);
        chk("out_beats", bus.out_beats, q_b[0]);
        chk("out_ovf", bus.out_ovf, q_o[0]);
        chk("in_ready_while_out", bus.in_ready, 1'b0);
        if (rdy) begin
          void'(q_y.pop_front());
          void'(q_b.pop_front());
          void'(q_o.pop_front());
        end
      end
    end
    if (acc) model_beat(x, last);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void model_clear();
    m_total = 128'd0;
    m_beats = 0;
    q_y.delete();
    q_b.delete();
    q_o.delete();
  endfunction

  initial begin
    bit acc;
    int low;
    int guard;
    int nb;
    int cnt;
    logic [N*W-1:0] x;

    checks = 0; failures = 0;
    clk = 1'b0; rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_x = '0; bus.out_ready = 1'b0;
    model_clear();

    repeat (2) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1'b0);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_y", bus.out_y, 32'd0);
    chk("reset_out_beats", bus.out_beats, 16'd0);
    chk("reset_out_ovf", bus.out_ovf, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ready_after_reset", bus.in_ready, 1'b1);

    // Single beat, operands 1..9, latency exactly two cycles.
    for (int i = 0; i < N; i++) x[i*W +: W] = W'(i + 1);
    cycle(1'b1, 1'b1, x, 1'b0, acc);
    chk("t1_accepted", acc, 1'b1);
    chk("t1_valid_at_t1", bus.out_valid, 1'b0);
    chk("t1_ready_resolve", bus.in_ready, 1'b0);
    cycle(1'b0, 1'b0, rand_x(), 1'b0, acc);
    chk("t1_valid_at_t2", bus.out_valid, 1'b1);
    chk("t1_y", bus.out_y, 32'd45);
    chk("t1_beats", bus.out_beats, 16'd1);
    cycle(1'b0, 1'b0, rand_x(), 1'b1, acc);
    chk("t1_ready_after_out", bus.in_ready, 1'b1);

    // Three beats of all-ones operands.
    for (int b = 0; b < 3; b++) cycle(1'b1, b == 2, fill_x(32'hFFFF_FFFF), 1'b0, acc);
    cycle(1'b0, 1'b0, '0, 1'b0, acc);
    chk("t2_y", bus.out_y, 32'hFFFF_FFE5);
    chk("t2_beats", bus.out_beats, 16'd3);
`ifdef CSA_ACC_OVF_EN
    chk("t2_ovf", bus.out_ovf, 1'b1);
`else
    chk("t2_ovf", bus.out_ovf, 1'b0);
`endif
    cycle(1'b0, 1'b0, '0, 1'b1, acc);

    // Back-to-back random packets, in_valid and out_ready held high.
    for (int p = 0; p < 5; p++) begin
      nb = $urandom_range(1, 5);
      low = 0;
      for (int b = 0; b < nb; b++) begin
        guard = 0;
        do begin
          cycle(1'b1, b == nb - 1, rand_x(), 1'b1, acc);
          if (!acc) low++;
          guard++;
        end while (!acc && guard < 10);
        if (!acc) chk("b2b_timeout", acc, 1'b1);
        if (b == 0 && p > 0) chk("b2b_ready_low", low, 2);
      end
    end
    repeat (3) cycle(1'b0, 1'b0, rand_x(), 1'b1, acc);
    chk("b2b_drained", q_y.size(), 0);

    // Stall in OUT for five cycles with beats offered.
    cycle(1'b1, 1'b0, rand_x(), 1'b0, acc);
    cycle(1'b1, 1'b1, rand_x(), 1'b0, acc);
    cycle(1'b0, 1'b0, rand_x(), 1'b0, acc);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, $urandom_range(0, 1) == 1, rand_x(), 1'b0, acc);
      chk("stall_no_accept", acc, 1'b0);
    end
    cycle(1'b1, 1'b0, rand_x(), 1'b1, acc);
    chk("stall_release_no_accept", acc, 1'b0);
    cycle(1'b1, 1'b1, rand_x(), 1'b1, acc);
    chk("resume_accept", acc, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, rand_x(), 1'b1, acc);
    chk("stall_drained", q_y.size(), 0);

    // Reset after two of four beats; state is dropped immediately.
    cycle(1'b1, 1'b0, rand_x(), 1'b1, acc);
    cycle(1'b1, 1'b0, rand_x(), 1'b1, acc);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_y", bus.out_y, 32'd0);
    chk("rst_out_beats", bus.out_beats, 16'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    cycle(1'b1, 1'b1, fill_x(32'd2), 1'b1, acc);
    chk("rst_twos_accept", acc, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b0, acc);
    chk("rst_twos_y", bus.out_y, 32'd18);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);

    // Reset while a result is waiting in OUT.
    cycle(1'b1, 1'b1, rand_x(), 1'b0, acc);
    cycle(1'b0, 1'b0, '0, 1'b0, acc);
    chk("out_rst_pre_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("out_rst_valid", bus.out_valid, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    chk("out_rst_ready", bus.in_ready, 1'b1);

    // 70001-beat packet: beat counter saturates, sum keeps counting.
    x = '0;
    x[0 +: W] = 32'd1;
    cnt = 0;
    for (int k = 0; k < 70000; k++) begin
      cycle(1'b1, 1'b0, x, 1'b1, acc);
      if (acc) cnt++;
    end
    chk("long_accepted", cnt, 70000);
    cycle(1'b1, 1'b1, x, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, 1'b0, acc);
    chk("long_beats", bus.out_beats, 16'hFFFF);
    chk("long_y", bus.out_y, 32'd70001);
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
    chk("long_drained", q_y.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
